y_rle_encoder: RTL

Y_RLE_ENCODER -- requirements
Module: y_rle_encoder

---
 rtl/jpeg_rle_pkg.sv | 37 +++
 rtl/y_rle_encoder_if.sv | 32 +++
 rtl/jpeg_size_category.sv | 42 ++++
 rtl/y_rle_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/jpeg_rle_pkg.sv
`default_nettype none
// ============================================================================
// Package     : jpeg_rle_pkg
// Description : Shared types and constants for the luma run-length encoder:
//               FSM state encoding, JPEG zigzag scan table and the fixed
//               run/size encodings of the ZRL and EOB symbols.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_rle_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DC   = 3'd1,
    AC   = 3'd2,
    EOB  = 3'd3,
    DONE = 3'd4
  } rle_state_t;

  // Zigzag position k -> {row[2:0], col[2:0]} of the 8x8 block (0-based).
  // The packed value equals the natural raster index row*8+col.
  localparam logic [5:0] ZIGZAG_RC [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // {run[3:0], size[3:0]} of the two special AC symbols
  localparam logic [7:0] ZRL_RUNSIZE = 8'hF0;
  localparam logic [7:0] EOB_RUNSIZE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/y_rle_encoder_if.sv
`default_nettype none
// ============================================================================
// Interface   : y_rle_encoder_if
// Description : Valid/ready symbol channel from the RLE encoder to the
//               Huffman stage.
//               sym_valid/sym_ready : handshake
//               sym_dc              : symbol is the DC difference
//               sym_run / sym_size  : zero run and magnitude category
//               sym_amp             : JPEG amplitude bits
// Revision    : 1.0 - initial release
// ============================================================================
interface y_rle_encoder_if #(
  parameter int COEF_W = 11
);
  logic              sym_valid;
  logic              sym_ready;
  logic              sym_dc;
  logic [3:0]        sym_run;
  logic [3:0]        sym_size;
  logic [COEF_W-1:0] sym_amp;

  modport master (
    output sym_valid, sym_dc, sym_run, sym_size, sym_amp,
    input  sym_ready
  );

  modport slave (
    input  sym_valid, sym_dc, sym_run, sym_size, sym_amp,
    output sym_ready
  );
endinterface
`default_nettype wire

// File: rtl/jpeg_size_category.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_size_category
// Description : Combinational JPEG magnitude category and amplitude bits.
//               x    : signed input value (IN_W bits)
//               size : bit length of |x|, 0 for x = 0
//               amp  : x for x > 0, else low 'size' bits of (x - 1)
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_size_category #(
  parameter int IN_W  = 12,
  parameter int AMP_W = 11
) (
  input  logic signed [IN_W-1:0]  x,
  output logic        [3:0]       size,
  output logic        [AMP_W-1:0] amp
);

  logic [IN_W-1:0]  w_mag;
  logic [AMP_W-1:0] w_x_lo;
  logic [AMP_W-1:0] w_amp_mask;
  logic             w_pos;

  // The most negative value negates to itself; read unsigned it is still the
  // correct magnitude.
  assign w_mag  = x[IN_W-1] ? IN_W'(-x) : x;
  assign w_pos  = !x[IN_W-1] && (x != '0);
  // Low bits of (x - 1) depend only on the low bits of x
  assign w_x_lo = x[AMP_W-1:0];

  always_comb begin
    size = 4'd0;
    for (int i = 0; i < IN_W; i++) begin
      if (w_mag[i]) size = 4'(i + 1);
    end
  end

  assign w_amp_mask = ~({AMP_W{1'b1}} << size);
  assign amp        = w_pos ? w_x_lo : ((w_x_lo - AMP_W'(1)) & w_amp_mask);

endmodule
`default_nettype wire

// File: rtl/y_rle_encoder.sv
`default_nettype none
// ============================================================================
// Module      : y_rle_encoder
// Description : JPEG luma run-length encoder. Captures a quantized 8x8 block,
//               emits the DC difference symbol, then scans the AC
//               coefficients in zigzag order producing (run, size, amp)
//               symbols, ZRL and EOB over a valid/ready channel.
//               clk        : clock, rising edge
//               rst        : asynchronous active-low reset
//               enable     : 1-cycle pulse, Q holds a valid block
//               Q          : signed quantized coefficients, [row][col] 1..8
//               dc_clear   : zero the DC predictor (honoured in IDLE)
//               sym_if     : symbol channel (master side)
//               busy       : a block is being encoded
//               block_done : 1-cycle pulse after the final symbol is taken
//               overrun    : sticky, enable seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module y_rle_encoder
  import jpeg_rle_pkg::*;
#(
  parameter int COEF_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [COEF_W-1:0] Q [1:8][1:8],
  input  logic                     dc_clear,
  y_rle_encoder_if.master          sym_if,
  output logic                     busy,
  output logic                     block_done,
  output logic                     overrun
);

  rle_state_t               r_state;
  logic signed [COEF_W-1:0] r_buf [64];   // zigzag order
  logic [63:0]              r_mask;       // zigzag order, 1 = nonzero
  logic [5:0]               r_k;
  logic [3:0]               r_run;
  logic                     r_last;       // pending symbol ends the block
  logic signed [COEF_W-1:0] r_dc_pred;
  logic                     r_sym_valid;
  logic                     r_sym_dc;
  logic [3:0]               r_sym_run;
  logic [3:0]               r_sym_size;
  logic [COEF_W-1:0]        r_sym_amp;
  logic                     r_busy;
  logic                     r_block_done;
  logic                     r_overrun;

  logic signed [COEF_W:0]   w_diff;
  logic signed [COEF_W:0]   w_cat_in;
  logic signed [COEF_W-1:0] w_coef;
  logic [3:0]               w_size;
  logic [COEF_W-1:0]        w_amp;
  logic                     w_accept;
  logic                     w_slot_free;
  logic                     w_tail_nz;

  assign w_accept    = r_sym_valid && sym_if.sym_ready;
  assign w_slot_free = !r_sym_valid || sym_if.sym_ready;
  assign w_coef      = r_buf[r_k];
  // Any nonzero coefficient at zigzag position >= k, i.e. k <= last_nz
  assign w_tail_nz   = |(r_mask >> r_k);
  assign w_diff      = {r_buf[0][COEF_W-1], r_buf[0]} - {r_dc_pred[COEF_W-1], r_dc_pred};

  // One category unit serves both paths: DC only uses it in the DC state
  assign w_cat_in = (r_state == DC) ? w_diff : {w_coef[COEF_W-1], w_coef};

  // A DC difference needing COEF_W+1 bits loses its amp MSB on the
  // COEF_W-wide channel; size still reports the full category.
  jpeg_size_category #(
    .IN_W  (COEF_W + 1),
    .AMP_W (COEF_W)
  ) u_size_category (
    .x    (w_cat_in),
    .size (w_size),
    .amp  (w_amp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      for (int i = 0; i < 64; i++) r_buf[i] <= '0;
      r_mask       <= '0;
      r_k          <= '0;
      r_run        <= '0;
      r_last       <= 1'b0;
      r_dc_pred    <= '0;
      r_sym_valid  <= 1'b0;
      r_sym_dc     <= 1'b0;
      r_sym_run    <= '0;
      r_sym_size   <= '0;
      r_sym_amp    <= '0;
      r_busy       <= 1'b0;
      r_block_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_block_done <= 1'b0;
      if (w_accept) r_sym_valid <= 1'b0;
      if (w_accept && r_sym_dc) r_dc_pred <= r_buf[0];
      if (enable && r_busy) r_overrun <= 1'b1;

      if (r_last) begin
        // Final symbol of the block is pending; finish on its acceptance
        if (w_accept) begin
          r_last       <= 1'b0;
          r_block_done <= 1'b1;
          r_state      <= DONE;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (dc_clear) r_dc_pred <= '0;
            if (enable) begin
              for (int i = 0; i < 64; i++) begin
                r_buf[i]  <= Q[32'(ZIGZAG_RC[i][5:3]) + 1][32'(ZIGZAG_RC[i][2:0]) + 1];
                r_mask[i] <= (Q[32'(ZIGZAG_RC[i][5:3]) + 1][32'(ZIGZAG_RC[i][2:0]) + 1] != '0);
              end
              r_busy  <= 1'b1;
              r_state <= DC;
            end
          end

          DC: begin
            // No symbol can be pending on entry, so emit unconditionally
            r_sym_valid <= 1'b1;
            r_sym_dc    <= 1'b1;
            r_sym_run   <= 4'd0;
            r_sym_size  <= w_size;
            r_sym_amp   <= w_amp;
            r_k         <= 6'd1;
            r_run       <= 4'd0;
            r_state     <= AC;
          end

          AC: begin
            if (w_slot_free) begin
              if (!w_tail_nz) begin
                r_state <= EOB;
              end else if (w_coef != '0) begin
                r_sym_valid <= 1'b1;
                r_sym_dc    <= 1'b0;
                r_sym_run   <= r_run;
                r_sym_size  <= w_size;
                r_sym_amp   <= w_amp;
                r_run       <= 4'd0;
                // A nonzero at k=63 ends the block without an EOB
                if (r_k == 6'd63) r_last <= 1'b1;
                else              r_k    <= r_k + 6'd1;
              end else if (r_run == 4'd15) begin
                // 16th consecutive zero with more nonzeros ahead
                r_sym_valid <= 1'b1;
                r_sym_dc    <= 1'b0;
                {r_sym_run, r_sym_size} <= ZRL_RUNSIZE;
                r_sym_amp   <= '0;
                r_run       <= 4'd0;
                r_k         <= r_k + 6'd1;
              end else begin
                r_run <= r_run + 4'd1;
                r_k   <= r_k + 6'd1;
              end
            end
          end

          EOB: begin
            if (w_slot_free) begin
              r_sym_valid <= 1'b1;
              r_sym_dc    <= 1'b0;
              {r_sym_run, r_sym_size} <= EOB_RUNSIZE;
              r_sym_amp   <= '0;
              r_last      <= 1'b1;
            end
          end

          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sym_if.sym_valid = r_sym_valid;
  assign sym_if.sym_dc    = r_sym_dc;
  assign sym_if.sym_run   = r_sym_run;
  assign sym_if.sym_size  = r_sym_size;
  assign sym_if.sym_amp   = r_sym_amp;
  assign busy             = r_busy;
  assign block_done       = r_block_done;
  assign overrun          = r_overrun;

endmodule
`default_nettype wire
